// File: rtl/pipeline_pkg.sv
// Shared definitions for the hazard unit: forward-select codes, load
// encoding, the shadow stage record and the forward-select helper.
package pipeline_pkg;

  // Width of the address fields held in the shadow pipeline.
  // The top zero-extends its register addresses into this width.
  localparam int SHADOW_AW = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_W    = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic [SHADOW_AW-1:0] rs1;
    logic [SHADOW_AW-1:0] rs2;
    logic [SHADOW_AW-1:0] rd;
    logic                 wr;
    logic                 load;
  } stage_t;

  // M beats W; x0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [SHADOW_AW-1:0] rs,
    input logic [SHADOW_AW-1:0] rd_m,
    input logic                 wr_m,
    input logic [SHADOW_AW-1:0] rd_w,
    input logic                 wr_w
  );
    if (wr_m && (rd_m != '0) && (rd_m == rs))      return FWD_M;
    else if (wr_w && (rd_w != '0) && (rd_w == rs)) return FWD_W;
    else                                           return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_track.sv
// Shadow E/M/W register-address pipeline. Advances with the same enable
// the hazard unit issues to the datapath; eclr_i loads a bubble into E.
module hazard_track
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic                 eclr_i,
  input  stage_t               d_i,
  output stage_t               e_o,
  output logic [SHADOW_AW-1:0] rdM_o,
  output logic                 wrM_o,
  output logic [SHADOW_AW-1:0] rdW_o,
  output logic                 wrW_o
);

  stage_t               r_e;
  logic [SHADOW_AW-1:0] r_rdM, r_rdW;
  logic                 r_wrM, r_wrW;

  // E stage: take the D record, or a bubble when flushed/stalled behind a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_e <= '0;
    else if (en_i) r_e <= eclr_i ? '0 : d_i;
  end

  // M and W stages: only the write-back identity is needed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdM <= '0;
      r_wrM <= 1'b0;
      r_rdW <= '0;
      r_wrW <= 1'b0;
    end else if (en_i) begin
      r_rdM <= r_e.rd;
      r_wrM <= r_e.wr;
      r_rdW <= r_rdM;
      r_wrW <= r_wrM;
    end
  end

  assign e_o   = r_e;
  assign rdM_o = r_rdM;
  assign wrM_o = r_wrM;
  assign rdW_o = r_rdW;
  assign wrW_o = r_wrW;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: stall/flush/enable generation, E-stage forwarding
// selects and a saturating stall-cycle counter.
module hazard_unit #(
  parameter int         REG_AW    = 5,
  parameter int         CNT_WIDTH = 16,
  parameter logic [1:0] RES_LOAD  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_AW-1:0]    Rs1D_i,
  input  logic [REG_AW-1:0]    Rs2D_i,
  input  logic [REG_AW-1:0]    RdD_i,
  input  logic [2:0]           RegWriteD_i,
  input  logic [1:0]           ResultSrcD_i,
  input  logic [1:0]           PCSrcE_i,
  input  logic                 MemBusyM_i,
  output logic                 PCen_o,
  output logic                 Fen_o,
  output logic                 Frst_o,
  output logic                 Den_o,
  output logic                 Drst_o,
  output logic                 Men_o,
  output logic [1:0]           ForwardAE_o,
  output logic [1:0]           ForwardBE_o,
  output logic [CNT_WIDTH-1:0] StallCnt_o
);
  import pipeline_pkg::*;

  stage_t               w_d, w_e;
  logic [SHADOW_AW-1:0] w_rdM, w_rdW;
  logic                 w_wrM, w_wrW;
  logic                 w_busy, w_redir, w_lu, w_stall;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Register addresses are zero-extended into the shadow width (REG_AW <= SHADOW_AW).
  assign w_d.rs1  = SHADOW_AW'(Rs1D_i);
  assign w_d.rs2  = SHADOW_AW'(Rs2D_i);
  assign w_d.rd   = SHADOW_AW'(RdD_i);
  assign w_d.wr   = |RegWriteD_i;
  assign w_d.load = (ResultSrcD_i == RES_LOAD);

  assign w_busy  = MemBusyM_i;
  assign w_redir = |PCSrcE_i;
  assign w_lu    = w_e.load && w_e.wr && (w_e.rd != '0) &&
                   ((w_e.rd == w_d.rs1) || (w_e.rd == w_d.rs2));

  // A redirect flushes the dependent instruction, so it never counts as a stall.
  assign w_stall = w_busy || (w_lu && !w_redir);

  hazard_track u_track (
    .clk    (clk),
    .rst_n  (rst),
    .en_i   (!w_busy),
    .eclr_i (w_redir || w_lu),
    .d_i    (w_d),
    .e_o    (w_e),
    .rdM_o  (w_rdM),
    .wrM_o  (w_wrM),
    .rdW_o  (w_rdW),
    .wrW_o  (w_wrW)
  );

  // Priority decode busy > redirect > load-use; reset overrides combinationally.
  always_comb begin
    PCen_o      = 1'b1;
    Fen_o       = 1'b1;
    Den_o       = 1'b1;
    Men_o       = 1'b1;
    Frst_o      = 1'b0;
    Drst_o      = 1'b0;
    ForwardAE_o = fwd_sel(w_e.rs1, w_rdM, w_wrM, w_rdW, w_wrW);
    ForwardBE_o = fwd_sel(w_e.rs2, w_rdM, w_wrM, w_rdW, w_wrW);
    if (!rst) begin
      PCen_o      = 1'b0;
      Fen_o       = 1'b0;
      Den_o       = 1'b0;
      Men_o       = 1'b0;
      Frst_o      = 1'b1;
      Drst_o      = 1'b1;
      ForwardAE_o = FWD_RF;
      ForwardBE_o = FWD_RF;
    end else if (w_busy) begin
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Den_o  = 1'b0;
      Men_o  = 1'b0;
    end else if (w_redir) begin
      Frst_o = 1'b1;
      Drst_o = 1'b1;
    end else if (w_lu) begin
      PCen_o = 1'b0;
      Fen_o  = 1'b0;
      Drst_o = 1'b1;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          r_cnt <= '0;
    else if (w_stall && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
  end

  assign StallCnt_o = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit (4-bit stall counter to reach saturation).
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D_i, Rs2D_i, RdD_i;
  logic [2:0] RegWriteD_i;
  logic [1:0] ResultSrcD_i, PCSrcE_i;
  logic       MemBusyM_i;
  logic       PCen_o, Fen_o, Frst_o, Den_o, Drst_o, Men_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic [3:0] StallCnt_o;

  int checks   = 0;
  int failures = 0;

  hazard_unit #(.REG_AW(5), .CNT_WIDTH(4), .RES_LOAD(2'b01)) dut (
    .clk          (clk),
    .rst          (rst),
    .Rs1D_i       (Rs1D_i),
    .Rs2D_i       (Rs2D_i),
    .RdD_i        (RdD_i),
    .RegWriteD_i  (RegWriteD_i),
    .ResultSrcD_i (ResultSrcD_i),
    .PCSrcE_i     (PCSrcE_i),
    .MemBusyM_i   (MemBusyM_i),
    .PCen_o       (PCen_o),
    .Fen_o        (Fen_o),
    .Frst_o       (Frst_o),
    .Den_o        (Den_o),
    .Drst_o       (Drst_o),
    .Men_o        (Men_o),
    .ForwardAE_o  (ForwardAE_o),
    .ForwardBE_o  (ForwardBE_o),
    .StallCnt_o   (StallCnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed control word {PCen,Fen,Frst,Den,Drst,Men}.
  function automatic logic [5:0] ctl();
    return {PCen_o, Fen_o, Frst_o, Den_o, Drst_o, Men_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [2:0] wr, input logic [1:0] rsrc);
    Rs1D_i = rs1; Rs2D_i = rs2; RdD_i = rd; RegWriteD_i = wr; ResultSrcD_i = rsrc;
  endtask

  localparam logic [5:0] CTL_RUN  = 6'b110101;
  localparam logic [5:0] CTL_RST  = 6'b001010;
  localparam logic [5:0] CTL_BUSY = 6'b000000;
  localparam logic [5:0] CTL_LU   = 6'b000111;
  localparam logic [5:0] CTL_RDIR = 6'b111111;

  initial begin
    rst = 1'b0; PCSrcE_i = 2'b00; MemBusyM_i = 1'b0;
    set_d(0, 0, 0, 0, 2'b00);

    // Reset held three cycles.
    repeat (3) tick();
    chk("reset_ctl", ctl(), CTL_RST);
    chk("reset_fwdA", ForwardAE_o, 2'b00);
    chk("reset_cnt", StallCnt_o, 0);
    #1 rst = 1'b1;
    tick();
    chk("idle_ctl", ctl(), CTL_RUN);
    chk("idle_fwdA", ForwardAE_o, 2'b00);
    chk("idle_fwdB", ForwardBE_o, 2'b00);

    // Back-to-back ALU dependency: forward from M.
    set_d(0, 0, 5, 1, 2'b00); tick();
    set_d(5, 0, 6, 1, 2'b00); tick();
    chk("fwd_m_A", ForwardAE_o, 2'b10);
    chk("fwd_m_B", ForwardBE_o, 2'b00);

    // One unrelated instruction in between: forward from W.
    set_d(0, 0, 9, 1, 2'b00); tick();
    set_d(1, 0, 0, 0, 2'b00); tick();
    set_d(9, 0, 0, 0, 2'b00); tick();
    chk("fwd_w_A", ForwardAE_o, 2'b01);

    // Writer of x0 must not forward.
    set_d(0, 0, 0, 1, 2'b00); tick();
    set_d(0, 0, 0, 0, 2'b00); tick();
    chk("fwd_x0_A", ForwardAE_o, 2'b00);

    // Same rd in both M and W: M wins.
    set_d(0, 0, 3, 1, 2'b00); tick();
    set_d(0, 0, 3, 1, 2'b00); tick();
    set_d(0, 3, 0, 0, 2'b00); tick();
    chk("fwd_prio_B", ForwardBE_o, 2'b10);

    // Load-use on rs2: one stall cycle, then forward from W.
    set_d(0, 0, 7, 1, 2'b01); tick();
    set_d(0, 7, 10, 1, 2'b00); #1;
    chk("lu_ctl", ctl(), CTL_LU);
    chk("lu_cnt_before", StallCnt_o, 0);
    tick();
    chk("lu_cnt", StallCnt_o, 1);
    chk("lu_release_ctl", ctl(), CTL_RUN);
    tick();
    chk("lu_fwdB", ForwardBE_o, 2'b01);
    chk("lu_once_ctl", ctl(), CTL_RUN);

    // Redirect together with a load-use: flush, no stall.
    set_d(0, 0, 7, 1, 2'b01); tick();
    set_d(0, 7, 10, 1, 2'b00); PCSrcE_i = 2'b10; #1;
    chk("redir_ctl", ctl(), CTL_RDIR);
    tick();
    chk("redir_cnt", StallCnt_o, 1);
    PCSrcE_i = 2'b00; set_d(0, 7, 0, 0, 2'b00); #1;
    chk("redir_bubble_ctl", ctl(), CTL_RUN);

    // Memory busy for four cycles mid-stream.
    set_d(0, 0, 12, 1, 2'b00); tick();
    set_d(12, 0, 13, 1, 2'b00); tick();
    set_d(13, 0, 14, 1, 2'b00);
    MemBusyM_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("busy_ctl", ctl(), CTL_BUSY);
      chk("busy_fwdA", ForwardAE_o, 2'b10);
      tick();
    end
    MemBusyM_i = 1'b0; #1;
    chk("busy_cnt", StallCnt_o, 5);
    chk("busy_hold_fwdA", ForwardAE_o, 2'b10);
    tick();
    chk("resume_fwdA", ForwardAE_o, 2'b10);
    set_d(12, 13, 0, 0, 2'b00); tick();
    chk("resume_nodup_A", ForwardAE_o, 2'b00);
    chk("resume_nolost_B", ForwardBE_o, 2'b01);

    // Twenty busy cycles saturate the 4-bit counter.
    set_d(0, 0, 0, 0, 2'b00);
    MemBusyM_i = 1'b1;
    repeat (20) tick();
    chk("sat_cnt", StallCnt_o, 15);
    MemBusyM_i = 1'b0; #1;
    chk("sat_run_ctl", ctl(), CTL_RUN);

    // Asynchronous reset mid-cycle, well away from any clock edge.
    #2 rst = 1'b0; #1;
    chk("async_ctl", ctl(), CTL_RST);
    chk("async_cnt", StallCnt_o, 0);
    #1 rst = 1'b1; #1;
    chk("async_release_ctl", ctl(), CTL_RUN);
    tick();
    chk("async_release_cnt", StallCnt_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
